// File: rtl/fetcher.sv
// fetcher: per-warp instruction fetch sequencer with round-robin issue, branch parking and sync barrier
module fetcher #(
    parameter int PcWidth        = 32,
    parameter int NumWarps       = 8,
    parameter int WarpWidth      = 32,
    parameter int WidWidth       = NumWarps > 1 ? $clog2(NumWarps) : 1,
    parameter int SubwarpIdWidth = WarpWidth > 1 ? $clog2(WarpWidth) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_valid_i,
    output logic                      start_ready_o,
    input  logic [WidWidth-1:0]       start_warp_id_i,
    input  logic [PcWidth-1:0]        start_pc_i,
    input  logic [WarpWidth-1:0]      start_act_mask_i,
    input  logic                      ic_ready_i,
    output logic                      fe_valid_o,
    output logic [PcWidth-1:0]        fe_pc_o,
    output logic [WarpWidth-1:0]      fe_act_mask_o,
    output logic [WidWidth-1:0]       fe_warp_id_o,
    output logic [SubwarpIdWidth-1:0] fe_subwarp_id_o,
    input  logic                      dec_decoded_i,
    input  logic                      dec_decoded_control_i,
    input  logic                      dec_stop_warp_i,
    input  logic                      dec_decoded_branch_i,
    input  logic                      dec_decoded_sync_i,
    input  logic [WidWidth-1:0]       dec_decoded_warp_id_i,
    input  logic [SubwarpIdWidth-1:0] dec_decoded_subwarp_id_i,
    input  logic [PcWidth-1:0]        dec_decoded_next_pc_i,
    input  logic                      bru_valid_i,
    input  logic [WidWidth-1:0]       bru_warp_id_i,
    input  logic [PcWidth-1:0]        bru_next_pc_i,
    output logic [NumWarps-1:0]       warp_active_o,
    output logic                      all_idle_o
);
    typedef enum logic [2:0] {IDLE, READY, WAIT_DEC, WAIT_BRU, WAIT_SYNC} state_e;

    state_e                r_state   [NumWarps];
    logic [PcWidth-1:0]    r_pc      [NumWarps];
    logic [WarpWidth-1:0]  r_mask    [NumWarps];
    state_e                w_state_nx[NumWarps];
    logic [PcWidth-1:0]    w_pc_nx   [NumWarps];
    logic [WarpWidth-1:0]  w_mask_nx [NumWarps];
    logic [WidWidth-1:0]   r_rr, r_lock_wid, w_arb, w_grant;
    logic [WidWidth:0]     w_sum;
    logic [NumWarps-1:0]   w_ready;
    logic                  r_locked, w_fire, w_all_sync, w_any_sync, w_sync_rel;
    logic                  w_unused;

    assign w_unused        = ^{dec_decoded_control_i, dec_decoded_subwarp_id_i};
    assign fe_valid_o      = |w_ready;
    assign w_fire          = fe_valid_o && ic_ready_i;
    assign w_grant         = r_locked ? r_lock_wid : w_arb;
    assign fe_pc_o         = r_pc[w_grant];
    assign fe_act_mask_o   = r_mask[w_grant];
    assign fe_warp_id_o    = w_grant;
    assign fe_subwarp_id_o = '0;
    assign all_idle_o      = ~|warp_active_o;
    assign start_ready_o   = r_state[start_warp_id_i] == IDLE;
    assign w_sync_rel      = w_all_sync && w_any_sync;

    // Per-warp status flags and barrier detection (stopped warps do not hold the barrier)
    always_comb begin
        w_ready       = '0;
        warp_active_o = '0;
        w_all_sync    = 1'b1;
        w_any_sync    = 1'b0;
        for (int w = 0; w < NumWarps; w++) begin
            w_ready[w]       = r_state[w] == READY;
            warp_active_o[w] = r_state[w] != IDLE;
            w_all_sync       = w_all_sync && (r_state[w] == IDLE || r_state[w] == WAIT_SYNC);
            w_any_sync       = w_any_sync || r_state[w] == WAIT_SYNC;
        end
    end

    // Round-robin search from r_rr; iterating downward lets the nearest READY warp win
    always_comb begin
        w_arb = r_rr;
        w_sum = '0;
        for (int i = NumWarps - 1; i >= 0; i--) begin
            w_sum = {1'b0, r_rr} + (WidWidth+1)'(i);
            w_sum = w_sum >= (WidWidth+1)'(NumWarps) ? w_sum - (WidWidth+1)'(NumWarps) : w_sum;
            if (w_ready[w_sum[WidWidth-1:0]]) w_arb = w_sum[WidWidth-1:0];
        end
    end

    // Per-warp next state; each warp reacts only to events addressed to its current state
    always_comb begin
        for (int w = 0; w < NumWarps; w++) begin
            w_state_nx[w] = r_state[w];
            w_pc_nx[w]    = r_pc[w];
            w_mask_nx[w]  = r_mask[w];
            if (r_state[w] == IDLE && start_valid_i && start_warp_id_i == WidWidth'(w)) begin
                w_state_nx[w] = READY;
                w_pc_nx[w]    = start_pc_i;
                w_mask_nx[w]  = start_act_mask_i;
            end else if (r_state[w] == READY && w_fire && w_grant == WidWidth'(w)) begin
                w_state_nx[w] = WAIT_DEC;
            end else if (r_state[w] == WAIT_DEC && dec_decoded_i && dec_decoded_warp_id_i == WidWidth'(w)) begin
                w_state_nx[w] = dec_stop_warp_i ? IDLE : dec_decoded_sync_i ? WAIT_SYNC :
                                dec_decoded_branch_i ? WAIT_BRU : READY;
                w_pc_nx[w]    = (dec_decoded_sync_i || !dec_decoded_branch_i) ? dec_decoded_next_pc_i : r_pc[w];
            end else if (r_state[w] == WAIT_BRU && bru_valid_i && bru_warp_id_i == WidWidth'(w)) begin
                w_state_nx[w] = READY;
                w_pc_nx[w]    = bru_next_pc_i;
            end else if (r_state[w] == WAIT_SYNC && w_sync_rel) begin
                w_state_nx[w] = READY;
            end
        end
    end

    // Per-warp state, PC and mask registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int w = 0; w < NumWarps; w++) begin
                r_state[w] <= IDLE;
                r_pc[w]    <= '0;
                r_mask[w]  <= '0;
            end
        end else begin
            for (int w = 0; w < NumWarps; w++) begin
                r_state[w] <= w_state_nx[w];
                r_pc[w]    <= w_pc_nx[w];
                r_mask[w]  <= w_mask_nx[w];
            end
        end
    end

    // Round-robin pointer advances past each accepted warp; a stalled grant is locked until accepted
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr       <= '0;
            r_locked   <= 1'b0;
            r_lock_wid <= '0;
        end else begin
            if (w_fire) r_rr <= w_grant == WidWidth'(NumWarps - 1) ? '0 : w_grant + 1'b1;
            r_locked   <= fe_valid_o && !ic_ready_i;
            r_lock_wid <= w_grant;
        end
    end

    a_dec_legal:   assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    dec_decoded_i |-> r_state[dec_decoded_warp_id_i] == WAIT_DEC);
    a_bru_legal:   assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    bru_valid_i |-> r_state[bru_warp_id_i] == WAIT_BRU);
    a_start_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    start_valid_i |-> start_ready_o);
endmodule

// File: tb/tb_fetcher.sv
// tb_fetcher: directed scenario tests for the fetcher
module tb_fetcher;
    localparam int PcW = 32, NW = 8, WW = 32, WidW = 3, SwW = 5;

    logic            clk_i = 1'b0, rst_ni = 1'b0;
    logic            start_valid_i = 1'b0, start_ready_o;
    logic [WidW-1:0] start_warp_id_i = '0;
    logic [PcW-1:0]  start_pc_i = '0;
    logic [WW-1:0]   start_act_mask_i = '0;
    logic            ic_ready_i = 1'b0, fe_valid_o;
    logic [PcW-1:0]  fe_pc_o;
    logic [WW-1:0]   fe_act_mask_o;
    logic [WidW-1:0] fe_warp_id_o;
    logic [SwW-1:0]  fe_subwarp_id_o;
    logic            dec_decoded_i = 1'b0, dec_decoded_control_i = 1'b0, dec_stop_warp_i = 1'b0;
    logic            dec_decoded_branch_i = 1'b0, dec_decoded_sync_i = 1'b0;
    logic [WidW-1:0] dec_decoded_warp_id_i = '0;
    logic [SwW-1:0]  dec_decoded_subwarp_id_i = '0;
    logic [PcW-1:0]  dec_decoded_next_pc_i = '0;
    logic            bru_valid_i = 1'b0;
    logic [WidW-1:0] bru_warp_id_i = '0;
    logic [PcW-1:0]  bru_next_pc_i = '0;
    logic [NW-1:0]   warp_active_o;
    logic            all_idle_o;

    int vectors = 0, miscompares = 0;

    fetcher dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .start_valid_i(start_valid_i), .start_ready_o(start_ready_o), .start_warp_id_i(start_warp_id_i),
        .start_pc_i(start_pc_i), .start_act_mask_i(start_act_mask_i),
        .ic_ready_i(ic_ready_i), .fe_valid_o(fe_valid_o), .fe_pc_o(fe_pc_o),
        .fe_act_mask_o(fe_act_mask_o), .fe_warp_id_o(fe_warp_id_o), .fe_subwarp_id_o(fe_subwarp_id_o),
        .dec_decoded_i(dec_decoded_i), .dec_decoded_control_i(dec_decoded_control_i),
        .dec_stop_warp_i(dec_stop_warp_i), .dec_decoded_branch_i(dec_decoded_branch_i),
        .dec_decoded_sync_i(dec_decoded_sync_i), .dec_decoded_warp_id_i(dec_decoded_warp_id_i),
        .dec_decoded_subwarp_id_i(dec_decoded_subwarp_id_i), .dec_decoded_next_pc_i(dec_decoded_next_pc_i),
        .bru_valid_i(bru_valid_i), .bru_warp_id_i(bru_warp_id_i), .bru_next_pc_i(bru_next_pc_i),
        .warp_active_o(warp_active_o), .all_idle_o(all_idle_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(negedge clk_i);
    endtask

    task automatic do_reset;
        rst_ni = 1'b0;
        ic_ready_i = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic launch(input logic [WidW-1:0] w, input logic [PcW-1:0] pc, input logic [WW-1:0] m);
        start_valid_i = 1'b1;
        start_warp_id_i = w;
        start_pc_i = pc;
        start_act_mask_i = m;
        tick();
        start_valid_i = 1'b0;
    endtask

    task automatic fb(input logic [WidW-1:0] w, input logic [PcW-1:0] npc,
                      input logic stop, input logic sync, input logic br);
        dec_decoded_i = 1'b1;
        dec_decoded_warp_id_i = w;
        dec_decoded_next_pc_i = npc;
        dec_stop_warp_i = stop;
        dec_decoded_sync_i = sync;
        dec_decoded_branch_i = br;
        tick();
        dec_decoded_i = 1'b0;
        dec_stop_warp_i = 1'b0;
        dec_decoded_sync_i = 1'b0;
        dec_decoded_branch_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        start_warp_id_i = 3'd0;
        tick();
        vectors++; if (fe_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_fe_valid: got %b expected 0", fe_valid_o); end
        vectors++; if (warp_active_o !== 8'h00) begin miscompares++; $display("FAIL reset_active: got %h expected 00", warp_active_o); end
        vectors++; if (all_idle_o !== 1'b1) begin miscompares++; $display("FAIL reset_all_idle: got %b expected 1", all_idle_o); end
        vectors++; if (start_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_start_ready: got %b expected 1", start_ready_o); end
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        do_reset();
        ic_ready_i = 1'b1;
        launch(3'd2, 32'h100, 32'hFFFF_FFFF);
        vectors++; if (fe_valid_o !== 1'b1) begin miscompares++; $display("FAIL basic_valid: got %b expected 1", fe_valid_o); end
        vectors++; if (fe_pc_o !== 32'h100) begin miscompares++; $display("FAIL basic_pc: got %h expected 100", fe_pc_o); end
        vectors++; if (fe_warp_id_o !== 3'd2) begin miscompares++; $display("FAIL basic_wid: got %0d expected 2", fe_warp_id_o); end
        vectors++; if (fe_act_mask_o !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL basic_mask: got %h expected ffffffff", fe_act_mask_o); end
        tick();
        vectors++; if (fe_valid_o !== 1'b0) begin miscompares++; $display("FAIL basic_inflight: got %b expected 0", fe_valid_o); end
        fb(3'd2, 32'h101, 1'b0, 1'b0, 1'b0);
        vectors++; if (fe_pc_o !== 32'h101 || fe_valid_o !== 1'b1) begin miscompares++; $display("FAIL basic_next_pc: got %b/%h expected 1/101", fe_valid_o, fe_pc_o); end
    endtask

    task automatic test_round_robin;
        do_reset();
        launch(3'd0, 32'h200, 32'h1);
        launch(3'd1, 32'h300, 32'h2);
        launch(3'd3, 32'h400, 32'h8);
        vectors++; if (fe_warp_id_o !== 3'd0 || fe_pc_o !== 32'h200) begin miscompares++; $display("FAIL rr_first: got %0d/%h expected 0/200", fe_warp_id_o, fe_pc_o); end
        ic_ready_i = 1'b1;
        tick();
        vectors++; if (fe_warp_id_o !== 3'd1) begin miscompares++; $display("FAIL rr_second: got %0d expected 1", fe_warp_id_o); end
        fb(3'd0, 32'h204, 1'b0, 1'b0, 1'b0);
        vectors++; if (fe_warp_id_o !== 3'd3) begin miscompares++; $display("FAIL rr_third: got %0d expected 3", fe_warp_id_o); end
        fb(3'd1, 32'h304, 1'b0, 1'b0, 1'b0);
        vectors++; if (fe_warp_id_o !== 3'd0 || fe_pc_o !== 32'h204) begin miscompares++; $display("FAIL rr_wrap: got %0d/%h expected 0/204", fe_warp_id_o, fe_pc_o); end
        fb(3'd3, 32'h404, 1'b0, 1'b0, 1'b0);
        vectors++; if (fe_warp_id_o !== 3'd1 || fe_pc_o !== 32'h304) begin miscompares++; $display("FAIL rr_pre_stall: got %0d/%h expected 1/304", fe_warp_id_o, fe_pc_o); end
        ic_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (fe_valid_o !== 1'b1 || fe_warp_id_o !== 3'd1 || fe_pc_o !== 32'h304 || fe_act_mask_o !== 32'h2) begin
                miscompares++; $display("FAIL rr_stall_%0d: got %b/%0d/%h/%h expected 1/1/304/2", i, fe_valid_o, fe_warp_id_o, fe_pc_o, fe_act_mask_o); end
        end
        ic_ready_i = 1'b1;
        tick();
        vectors++; if (fe_warp_id_o !== 3'd3 || fe_pc_o !== 32'h404) begin miscompares++; $display("FAIL rr_after_stall: got %0d/%h expected 3/404", fe_warp_id_o, fe_pc_o); end
    endtask

    task automatic test_branch;
        do_reset();
        ic_ready_i = 1'b1;
        launch(3'd1, 32'h10, 32'hF);
        vectors++; if (fe_warp_id_o !== 3'd1 || fe_pc_o !== 32'h10) begin miscompares++; $display("FAIL br_fetch: got %0d/%h expected 1/10", fe_warp_id_o, fe_pc_o); end
        tick();
        fb(3'd1, 32'h14, 1'b0, 1'b0, 1'b1);
        vectors++; if (fe_valid_o !== 1'b0) begin miscompares++; $display("FAIL br_parked: got %b expected 0", fe_valid_o); end
        tick();
        vectors++; if (fe_valid_o !== 1'b0 || warp_active_o !== 8'h02) begin miscompares++; $display("FAIL br_parked2: got %b/%h expected 0/02", fe_valid_o, warp_active_o); end
        bru_valid_i = 1'b1;
        bru_warp_id_i = 3'd1;
        bru_next_pc_i = 32'h40;
        tick();
        bru_valid_i = 1'b0;
        vectors++; if (fe_valid_o !== 1'b1 || fe_pc_o !== 32'h40 || fe_warp_id_o !== 3'd1) begin
            miscompares++; $display("FAIL br_resolved: got %b/%h/%0d expected 1/40/1", fe_valid_o, fe_pc_o, fe_warp_id_o); end
    endtask

    task automatic test_sync;
        do_reset();
        ic_ready_i = 1'b1;
        launch(3'd0, 32'h0, 32'h1);
        launch(3'd1, 32'h80, 32'h3);
        fb(3'd0, 32'h4, 1'b0, 1'b1, 1'b0);
        vectors++; if (fe_valid_o !== 1'b0 || warp_active_o !== 8'h03) begin miscompares++; $display("FAIL sync_stall: got %b/%h expected 0/03", fe_valid_o, warp_active_o); end
        fb(3'd1, 32'h84, 1'b0, 1'b1, 1'b0);
        vectors++; if (fe_valid_o !== 1'b0) begin miscompares++; $display("FAIL sync_both_wait: got %b expected 0", fe_valid_o); end
        tick();
        vectors++; if (fe_valid_o !== 1'b1 || fe_warp_id_o !== 3'd0 || fe_pc_o !== 32'h4) begin
            miscompares++; $display("FAIL sync_rel0: got %b/%0d/%h expected 1/0/4", fe_valid_o, fe_warp_id_o, fe_pc_o); end
        tick();
        vectors++; if (fe_valid_o !== 1'b1 || fe_warp_id_o !== 3'd1 || fe_pc_o !== 32'h84) begin
            miscompares++; $display("FAIL sync_rel1: got %b/%0d/%h expected 1/1/84", fe_valid_o, fe_warp_id_o, fe_pc_o); end
    endtask

    task automatic test_sync_stop;
        do_reset();
        ic_ready_i = 1'b1;
        launch(3'd0, 32'h0, 32'h1);
        launch(3'd1, 32'h80, 32'h3);
        fb(3'd0, 32'h4, 1'b0, 1'b1, 1'b0);
        fb(3'd1, 32'h0, 1'b1, 1'b0, 1'b0);
        vectors++; if (fe_valid_o !== 1'b0 || warp_active_o !== 8'h01) begin miscompares++; $display("FAIL stop_active: got %b/%h expected 0/01", fe_valid_o, warp_active_o); end
        tick();
        vectors++; if (fe_valid_o !== 1'b1 || fe_warp_id_o !== 3'd0 || fe_pc_o !== 32'h4) begin
            miscompares++; $display("FAIL stop_release: got %b/%0d/%h expected 1/0/4", fe_valid_o, fe_warp_id_o, fe_pc_o); end
        tick();
        vectors++; if (all_idle_o !== 1'b0) begin miscompares++; $display("FAIL stop_not_idle: got %b expected 0", all_idle_o); end
        fb(3'd0, 32'h0, 1'b1, 1'b0, 1'b0);
        vectors++; if (all_idle_o !== 1'b1 || warp_active_o !== 8'h00) begin miscompares++; $display("FAIL stop_all_idle: got %b/%h expected 1/00", all_idle_o, warp_active_o); end
    endtask

    task automatic test_async_reset;
        do_reset();
        ic_ready_i = 1'b1;
        launch(3'd4, 32'h500, 32'h10);
        launch(3'd5, 32'h600, 32'h20);
        vectors++; if (fe_valid_o !== 1'b1 || warp_active_o !== 8'h30) begin miscompares++; $display("FAIL ar_pre: got %b/%h expected 1/30", fe_valid_o, warp_active_o); end
        #2 rst_ni = 1'b0;
        #1;
        vectors++; if (fe_valid_o !== 1'b0) begin miscompares++; $display("FAIL ar_fe_valid: got %b expected 0", fe_valid_o); end
        vectors++; if (warp_active_o !== 8'h00 || all_idle_o !== 1'b1) begin miscompares++; $display("FAIL ar_active: got %h/%b expected 00/1", warp_active_o, all_idle_o); end
        tick();
        rst_ni = 1'b1;
        start_warp_id_i = 3'd4;
        tick();
        vectors++; if (start_ready_o !== 1'b1) begin miscompares++; $display("FAIL ar_start_ready: got %b expected 1", start_ready_o); end
        launch(3'd4, 32'h700, 32'h40);
        vectors++; if (fe_valid_o !== 1'b1 || fe_warp_id_o !== 3'd4 || fe_pc_o !== 32'h700 || fe_act_mask_o !== 32'h40) begin
            miscompares++; $display("FAIL ar_relaunch: got %b/%0d/%h/%h expected 1/4/700/40", fe_valid_o, fe_warp_id_o, fe_pc_o, fe_act_mask_o); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_branch();
        test_sync();
        test_sync_stop();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fetcher.md
Name: fetcher

Overview:
- Per-warp instruction fetch sequencer. It feeds the instruction-cache request port and closes the loop on the decoder's feedback bus (decoded / control / stop / branch / sync / next-PC).
- Holds one PC and active mask per warp and allows at most one instruction in flight per warp.
- Picks among ready warps round-robin.
- Parks warps on branches until the branch unit resolves them, and parks warps on sync until all live warps reach the barrier.

Parameters:
- PcWidth, 32, program counter width
- NumWarps, 8, warps per compute unit
- WarpWidth, 32, threads per warp (active-mask width)
- WidWidth, NumWarps>1 ? $clog2(NumWarps) : 1, derived; do not override
- SubwarpIdWidth, WarpWidth>1 ? $clog2(WarpWidth) : 1, derived; do not override

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- start_valid_i  in  1  launch a warp
- start_ready_o  out  1  high iff the warp at start_warp_id_i is IDLE
- start_warp_id_i  in  WidWidth  warp to launch
- start_pc_i  in  PcWidth  first PC
- start_act_mask_i  in  WarpWidth  initial active mask
- ic_ready_i  in  1  instruction cache accepts a request
- fe_valid_o  out  1  fetch request valid
- fe_pc_o  out  PcWidth  PC to fetch
- fe_act_mask_o  out  WarpWidth  mask of the fetching warp
- fe_warp_id_o  out  WidWidth  fetching warp
- fe_subwarp_id_o  out  SubwarpIdWidth  always '0 (reserved for divergence)
- dec_decoded_i  in  1  decoder finished an instruction
- dec_decoded_control_i  in  1  instruction was control-only
- dec_stop_warp_i  in  1  stop instruction
- dec_decoded_branch_i  in  1  conditional branch issued
- dec_decoded_sync_i  in  1  sync instruction
- dec_decoded_warp_id_i  in  WidWidth  warp of the feedback
- dec_decoded_subwarp_id_i  in  SubwarpIdWidth  ignored
- dec_decoded_next_pc_i  in  PcWidth  sequential or jump target
- bru_valid_i  in  1  branch resolved
- bru_warp_id_i  in  WidWidth  resolved warp
- bru_next_pc_i  in  PcWidth  resolved PC
- warp_active_o  out  NumWarps  bit w = warp w not IDLE
- all_idle_o  out  1  every warp IDLE

Behaviour:
- Reset (async, rst_ni=0):
  - all warps IDLE; PC and mask cleared
  - round-robin pointer = 0; lock register cleared
  - fe_valid_o=0, warp_active_o=0, all_idle_o=1, start_ready_o reflects IDLE (1)
- Per-warp states: IDLE, READY, WAIT_DEC, WAIT_BRU, WAIT_SYNC. Each transition below takes effect on the next edge.
- Launch: IDLE with start_valid_i && start_ready_o for that warp -> READY; load pc and mask.
- Fetch grant: READY, granted, and fe_valid_o && ic_ready_i -> WAIT_DEC.
- Decoder feedback, WAIT_DEC and dec_decoded_i with matching warp id. Priority order:
  - dec_stop_warp_i -> IDLE
  - dec_decoded_sync_i -> WAIT_SYNC, pc = dec_decoded_next_pc_i
  - dec_decoded_branch_i -> WAIT_BRU
  - otherwise -> READY, pc = dec_decoded_next_pc_i (covers jumps and sequential instructions)
- Branch resolve: WAIT_BRU with bru_valid_i and matching id -> READY, pc = bru_next_pc_i.
- Sync release: when every non-IDLE warp is in WAIT_SYNC (and at least one is), all of them -> READY in the same cycle. A warp stopping can complete the barrier for the others.
- Arbitration:
  - fe_valid_o = any warp READY.
  - Grant goes to the first READY warp searching from the rr pointer upward, with wrap-around.
  - On handshake, pointer = granted+1 mod NumWarps.
- Stability: if fe_valid_o && !ic_ready_i, lock the granted warp. fe_* must hold constant until the handshake; no re-arbitration while locked.
- Latency: a warp fetches no earlier than 1 cycle after it enters READY. Feedback to READY takes 1 cycle.
- Simultaneous events:
  - Fetch handshake, decoder feedback, bru resolve and start targeting different warps are all processed in the same cycle.
  - dec_decoded_i and bru_valid_i for the same warp cannot both be legal; the decoder wins.
- Illegal inputs (simulation assertion; RTL ignores them, no state change):
  - feedback for a warp not in WAIT_DEC
  - bru_valid_i for a warp not in WAIT_BRU
  - start_valid_i to a non-IDLE warp
- PC arithmetic: none internally; PCs are taken verbatim from the inputs.

Test Plan:
- Reset, then launch warp 2 at pc=0x100, mask=0xFFFF_FFFF, ic_ready_i=1 -> fe_valid_o, fe_pc_o=0x100, fe_warp_id_o=2. Feedback with next_pc=0x101 -> next fetch at 0x101.
- Warps 0, 1, 3 READY, ic_ready_i=1 -> grants 0, 1, 3, 0 on consecutive cycles. Hold ic_ready_i=0 for 3 cycles -> fe_* stable, grant unchanged.
- Warp 1 feedback with branch=1 -> warp 1 not fetched. bru_valid_i with id 1, next_pc=0x40 -> fetch 0x40 the following cycle.
- Warps 0 and 1 active, warp 0 syncs -> warp 0 stalls. Warp 1 then syncs -> both READY the next cycle, fetching their next_pc values.
- Warp 0 in WAIT_SYNC, warp 1 stops -> warp 0 released. After warp 0 also stops, all_idle_o=1.
- Assert rst_ni low while warp 4 is in WAIT_DEC -> immediately fe_valid_o=0 and warp_active_o=0. After release, warp 4 is launchable.
